// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
//
// Shares the single-port data memory between the CPU M-stage load/store path
// and a DMA/debug bridge. Each cycle one requester (or neither) is chosen.
// The chosen request is driven onto mem_* in the same cycle. The
// one-cycle-latency read data is steered back to whichever side issued the
// read.
//
// The CPU has fixed priority, with two exceptions:
//   * a DMA that has been refused MAX_WAIT cycles in a row wins the next
//     arbitration;
//   * a DMA holding dma_lock keeps the port for up to MAX_BURST consecutive
//     grants.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cpu_req_i/we/addr/wdata/byte   CPU request (must stay stable while stalled)
//   cpu_gnt_o, cpu_stall_o   CPU owns the port / CPU is being held off
//   cpu_rvalid_o, cpu_rdata_o      read return to the CPU
//   dma_req_i/we/addr/wdata/byte   DMA request
//   dma_lock_i               DMA asks for back-to-back grants
//   dma_gnt_o                DMA owns the port
//   dma_rvalid_o, dma_rdata_o      read return to the DMA
//   mem_en_o/we/addr/wdata/byte    memory port (byte enables zero on reads)
//   mem_rdata_i              memory read data, one cycle after a read
// -----------------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,  // 1..15
  parameter int unsigned MAX_BURST = 8   // 1..15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // CPU side
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_byte_i,
  output logic        cpu_gnt_o,
  output logic        cpu_stall_o,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_rdata_o,
  // DMA side
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  input  logic [3:0]  dma_byte_i,
  input  logic        dma_lock_i,
  output logic        dma_gnt_o,
  output logic        dma_rvalid_o,
  output logic [31:0] dma_rdata_o,
  // Memory port
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_byte_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU,
    ST_DMA,
    ST_DMA_LOCK
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_e;

  state_e     state_q, state_d;
  owner_e     rd_owner_q, rd_owner_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;

  logic cpu_gnt, dma_gnt;
  logic lock_hold;  // DMA keeps the port inside a locked burst
  logic starved;    // DMA has waited long enough to pre-empt the CPU

  // ---------------------------------------------------------------------------
  // Arbitration and next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cpu_gnt     = 1'b0;
    dma_gnt     = 1'b0;
    state_d     = ST_IDLE;
    rd_owner_d  = OWN_NONE;
    wait_cnt_d  = 4'd0;
    burst_cnt_d = 4'd0;

    lock_hold = (state_q == ST_DMA_LOCK) && dma_req_i && dma_lock_i &&
                (burst_cnt_q < MAX_BURST_C);
    starved   = dma_req_i && (wait_cnt_q >= MAX_WAIT_C);

    // Grants are suppressed while reset is asserted so that the port is
    // quiet even though arbitration is otherwise purely combinational.
    if (rst_ni) begin
      if (lock_hold || starved) begin
        dma_gnt = 1'b1;
      end else if (cpu_req_i) begin
        cpu_gnt = 1'b1;
      end else if (dma_req_i) begin
        dma_gnt = 1'b1;
      end
    end

    if (cpu_gnt) begin
      state_d = ST_CPU;
    end else if (dma_gnt && dma_lock_i) begin
      state_d = ST_DMA_LOCK;
    end else if (dma_gnt) begin
      state_d = ST_DMA;
    end

    // A locked grant that only won through normal priority (the burst limit
    // was reached) starts a fresh burst, so the count restarts at one.
    if (dma_gnt && dma_lock_i) begin
      burst_cnt_d = lock_hold ? (burst_cnt_q + 4'd1) : 4'd1;
    end

    if (dma_req_i && !dma_gnt) begin
      wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : (wait_cnt_q + 4'd1);
    end

    if (cpu_gnt && !cpu_we_i) begin
      rd_owner_d = OWN_CPU;
    end else if (dma_gnt && !dma_we_i) begin
      rd_owner_d = OWN_DMA;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      rd_owner_q  <= OWN_NONE;
      wait_cnt_q  <= 4'd0;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      rd_owner_q  <= rd_owner_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cpu_gnt_o   = cpu_gnt;
  assign dma_gnt_o   = dma_gnt;
  assign cpu_stall_o = rst_ni && cpu_req_i && !cpu_gnt;
  assign mem_en_o    = cpu_gnt | dma_gnt;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    mem_byte_o  = 4'd0;
    if (cpu_gnt) begin
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      mem_byte_o  = cpu_we_i ? cpu_byte_i : 4'd0;
    end else if (dma_gnt) begin
      mem_we_o    = dma_we_i;
      mem_addr_o  = dma_addr_i;
      mem_wdata_o = dma_wdata_i;
      mem_byte_o  = dma_we_i ? dma_byte_i : 4'd0;
    end
  end

  // rd_owner_q is cleared asynchronously, so a pending return vanishes on reset.
  assign cpu_rvalid_o = (rd_owner_q == OWN_CPU);
  assign dma_rvalid_o = (rd_owner_q == OWN_DMA);
  assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : 32'd0;
  assign dma_rdata_o  = dma_rvalid_o ? mem_rdata_i : 32'd0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
//
// Directed scenarios with literal expectations, followed by a randomized run.
// A behavioural model of the arbitration rules is checked against the DUT on
// every falling clock edge.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [3:0]  cpu_byte = 0;
  logic        dma_req = 0, dma_we = 0, dma_lock = 0;
  logic [31:0] dma_addr = 0, dma_wdata = 0;
  logic [3:0]  dma_byte = 0;
  logic [31:0] mem_rdata = 0;

  logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_byte;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_byte_i(cpu_byte),
    .cpu_gnt_o(cpu_gnt), .cpu_stall_o(cpu_stall),
    .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
    .dma_wdata_i(dma_wdata), .dma_byte_i(dma_byte), .dma_lock_i(dma_lock),
    .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_rdata_o(dma_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_byte_o(mem_byte), .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: who wins is decided from the plain rules, using a count
  // of consecutive refused DMA cycles, the length of the current locked run,
  // and which side (0 none, 1 cpu, 2 dma) has a read in flight.
  // ---------------------------------------------------------------------------
  int m_refused = 0;
  int m_run     = 0;
  bit m_locked  = 0;
  int m_reader  = 0;

  always @(negedge clk) begin
    bit keep, starve, e_dma, e_cpu, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_byte;
    if (!rst_n) begin
      chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
      chk("rst_dma_gnt", 32'(dma_gnt), 0);
      chk("rst_stall", 32'(cpu_stall), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_byte", 32'(mem_byte), 0);
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
      chk("rst_dma_rvalid", 32'(dma_rvalid), 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dma_rdata", dma_rdata, 0);
      m_refused = 0; m_run = 0; m_locked = 0; m_reader = 0;
    end else begin
      keep   = m_locked && dma_req && dma_lock && (m_run < MAX_BURST);
      starve = dma_req && (m_refused >= MAX_WAIT);
      e_dma  = keep || starve || (!cpu_req && dma_req);
      e_cpu  = !e_dma && cpu_req;
      e_we    = e_cpu ? cpu_we    : (e_dma ? dma_we    : 1'b0);
      e_addr  = e_cpu ? cpu_addr  : (e_dma ? dma_addr  : 32'd0);
      e_wdata = e_cpu ? cpu_wdata : (e_dma ? dma_wdata : 32'd0);
      e_byte  = !e_we ? 4'd0 : (e_cpu ? cpu_byte : dma_byte);

      chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
      chk("dma_gnt", 32'(dma_gnt), 32'(e_dma));
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cpu));
      chk("mem_en", 32'(mem_en), 32'(e_cpu || e_dma));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_byte", 32'(mem_byte), 32'(e_byte));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_reader == 1));
      chk("dma_rvalid", 32'(dma_rvalid), 32'(m_reader == 2));
      chk("cpu_rdata", cpu_rdata, (m_reader == 1) ? mem_rdata : 32'd0);
      chk("dma_rdata", dma_rdata, (m_reader == 2) ? mem_rdata : 32'd0);

      if (e_dma && dma_lock) m_run = keep ? m_run + 1 : 1;
      else                   m_run = 0;
      m_locked  = e_dma && dma_lock;
      m_refused = (dma_req && !e_dma) ? ((m_refused < 15) ? m_refused + 1 : 15) : 0;
      m_reader  = (e_cpu && !cpu_we) ? 1 : ((e_dma && !dma_we) ? 2 : 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge,
  // directed checks happen 1 time unit after the falling edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    mem_rdata = $urandom;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic quiet();
    cpu_req = 0; dma_req = 0; dma_lock = 0; cpu_we = 0; dma_we = 0;
  endtask

  initial begin
    // Scenario 1: reset held, released, nothing requested
    quiet();
    repeat (3) step();
    settle();
    chk("t1_in_reset_mem_en", 32'(mem_en), 0);
    step(); rst_n = 1;
    repeat (3) begin
      settle();
      chk("t1_idle_mem_en", 32'(mem_en), 0);
      chk("t1_idle_rvalid", 32'(cpu_rvalid | dma_rvalid), 0);
      step();
    end

    // Scenario 2: lone CPU read at 0x10
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    settle();
    chk("t2_cpu_gnt", 32'(cpu_gnt), 1);
    chk("t2_mem_addr", mem_addr, 32'h10);
    chk("t2_stall", 32'(cpu_stall), 0);
    step(); quiet(); mem_rdata = 32'hCAFE0001;
    settle();
    chk("t2_cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("t2_cpu_rdata", cpu_rdata, 32'hCAFE0001);
    chk("t2_stall_n1", 32'(cpu_stall), 0);
    step();

    // Scenario 3: both requesting continuously -> 4 CPU, 1 DMA, repeating
    cpu_req = 1; cpu_we = 1; cpu_byte = 4'hF;
    dma_req = 1; dma_we = 1; dma_byte = 4'h3; dma_lock = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("t3_dma_gnt", 32'(dma_gnt), 32'(i % 5 == 4));
      chk("t3_stall", 32'(cpu_stall), 32'(i % 5 == 4));
      step();
    end
    quiet(); step();

    // Scenario 4: locked DMA burst of 8, then CPU until DMA starves again
    dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 32'h200;
    for (int i = 0; i < 13; i++) begin
      settle();
      chk("t4_dma_gnt", 32'(dma_gnt), 32'(i < 8 || i == 12));
      step();
      cpu_req = 1; cpu_we = 1;
    end
    quiet(); step();

    // Scenario 5: DMA read then CPU store; DMA data returns under the store
    dma_req = 1; dma_we = 0; dma_addr = 32'h44;
    settle();
    chk("t5_dma_gnt", 32'(dma_gnt), 1);
    step(); quiet();
    cpu_req = 1; cpu_we = 1; cpu_byte = 4'hF; mem_rdata = 32'h12345678;
    settle();
    chk("t5_dma_rvalid", 32'(dma_rvalid), 1);
    chk("t5_dma_rdata", dma_rdata, 32'h12345678);
    chk("t5_mem_we", 32'(mem_we), 1);
    chk("t5_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("t5_cpu_rdata", cpu_rdata, 0);
    step(); quiet(); step();

    // Scenario 6: reset right after a CPU read grant discards the return
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
    settle();
    chk("t6_cpu_gnt", 32'(cpu_gnt), 1);
    step(); quiet(); rst_n = 0;
    repeat (2) begin
      settle();
      chk("t6_cpu_rvalid", 32'(cpu_rvalid), 0);
      chk("t6_mem_en", 32'(mem_en), 0);
      step();
    end
    rst_n = 1;

    // Randomized phase, with stretches of sustained locked DMA traffic
    for (int i = 0; i < 3000; i++) begin
      bit lock_mode;
      step();
      lock_mode = ((i / 60) % 3) == 1;
      rst_n     = ($urandom_range(0, 299) != 0);
      cpu_req   = ($urandom_range(0, 99) < 55);
      cpu_we    = $urandom_range(0, 1);
      cpu_addr  = $urandom; cpu_wdata = $urandom; cpu_byte = 4'($urandom);
      dma_req   = lock_mode ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) < 50);
      dma_lock  = lock_mode ? 1'b1 : ($urandom_range(0, 3) == 0);
      dma_we    = $urandom_range(0, 1);
      dma_addr  = $urandom; dma_wdata = $urandom; dma_byte = 4'($urandom);
    end
    step(); rst_n = 1; quiet();
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
